grn_scheduler: RTL and testbench

- Work scheduler that shares a pool of NUM_WORKERS grn trajectory engines across TOTAL_STATES initial configurations.
- Launches workers, arbitrates their completions round-robin, and writes each transient length into an external result memory indexed by the worker's returned configuration.
- Issues the next pending configuration to the worker it just served; retires workers once all configurations are issued.
- Sits between the top-level controller and the generated grn worker array.

---
 rtl/grn_pkg.sv | 21 ++
 rtl/grn_rr_arbiter.sv | 34 +++
 rtl/grn_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_grn_scheduler.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grn_pkg.sv
// Shared types and defaults for the grn work scheduler and its arbiter.
package grn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } t_sched_state;

  localparam int DEF_NUM_WORKERS  = 16;
  localparam int DEF_VEC_W        = 69;
  localparam int DEF_TOTAL_STATES = 16;
  localparam int DEF_RES_W        = 32;

  // Index width that never collapses to zero bits for degenerate sizes.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grn_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after pointer.
module grn_rr_arbiter
  import grn_pkg::*;
#(
  parameter int N     = 4,
  parameter int PTR_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             valid
);

  int idx;

  // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(pointer) + i;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/grn_scheduler.sv
// Shares NUM_WORKERS grn engines across TOTAL_STATES configurations and
// streams each finished run's transient length into the result memory.
module grn_scheduler
  import grn_pkg::*;
#(
  parameter int NUM_WORKERS  = DEF_NUM_WORKERS,
  parameter int VEC_W        = DEF_VEC_W,
  parameter int TOTAL_STATES = DEF_TOTAL_STATES,
  parameter int RES_W        = DEF_RES_W,
  parameter int IDX_W        = clog2_min1(TOTAL_STATES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  output logic                         busy,
  output logic                         finish,
  output logic                         err,
  output logic [NUM_WORKERS-1:0]       worker_start,
  output logic [NUM_WORKERS*VEC_W-1:0] worker_conf,
  output logic [NUM_WORKERS-1:0]       worker_ack,
  input  logic [NUM_WORKERS-1:0]       worker_done,
  input  logic [NUM_WORKERS*VEC_W-1:0] worker_conf_out,
  input  logic [NUM_WORKERS*RES_W-1:0] worker_transient,
  output logic                         res_we,
  output logic [IDX_W-1:0]             res_addr,
  output logic [RES_W-1:0]             res_data,
  output logic [IDX_W:0]               issued
);

  localparam int PTR_W    = clog2_min1(NUM_WORKERS);
  localparam int LAUNCH_N = (NUM_WORKERS < TOTAL_STATES) ? NUM_WORKERS : TOTAL_STATES;
  localparam logic [NUM_WORKERS-1:0] LAUNCH_MASK =
    {NUM_WORKERS{1'b1}} >> (NUM_WORKERS - LAUNCH_N);
  localparam logic [IDX_W:0] TOTAL = (IDX_W + 1)'(TOTAL_STATES);

  t_sched_state state_q, state_d;

  logic [NUM_WORKERS-1:0]            active_q, active_d;
  logic [NUM_WORKERS-1:0]            hold_q, hold_d;
  logic [PTR_W-1:0]                  ptr_q, ptr_d;
  logic [IDX_W:0]                    issued_q, issued_d;
  logic                              err_q, err_d;
  logic [NUM_WORKERS-1:0][VEC_W-1:0] conf_q, conf_d;
  logic [NUM_WORKERS-1:0]            start_q, start_d;
  logic [NUM_WORKERS-1:0]            ack_q, ack_d;
  logic                              we_q, we_d;
  logic [IDX_W-1:0]                  addr_q, addr_d;
  logic [RES_W-1:0]                  data_q, data_d;
  logic                              busy_q, busy_d;
  logic                              finish_q, finish_d;

  logic [NUM_WORKERS-1:0][VEC_W-1:0] conf_out;
  logic [NUM_WORKERS-1:0][RES_W-1:0] transient;
  logic [NUM_WORKERS-1:0]            req;
  logic [NUM_WORKERS-1:0]            grant;
  logic [PTR_W-1:0]                  grant_idx;
  logic                              grant_valid;
  logic [VEC_W-1:0]                  g_conf;
  logic                              g_in_range;
  logic                              go_ok;

  assign conf_out  = worker_conf_out;
  assign transient = worker_transient;
  assign go_ok     = go && (state_q == IDLE || state_q == FINISH);

  // The hold mask keeps a worker that is slow to drop done from being served twice.
  assign req = worker_done & active_q & ~hold_q & {NUM_WORKERS{state_q == RUN}};

  grn_rr_arbiter #(
    .N     (NUM_WORKERS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req),
    .pointer   (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  assign g_conf     = conf_out[grant_idx];
  assign g_in_range = ((g_conf >> IDX_W) == '0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FINISH: if (go) state_d = LAUNCH;
      LAUNCH:       state_d = RUN;
      RUN:          if (active_q == '0) state_d = FINISH;
      default:      state_d = IDLE;
    endcase
  end

  // Launch values are registered on the accepting edge so they are visible during LAUNCH.
  always_comb begin
    active_d = active_q;
    hold_d   = '0;
    ptr_d    = ptr_q;
    issued_d = issued_q;
    err_d    = err_q;
    conf_d   = conf_q;
    start_d  = '0;
    ack_d    = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    if (go_ok) begin
      active_d = LAUNCH_MASK;
      hold_d   = LAUNCH_MASK;
      start_d  = LAUNCH_MASK;
      ptr_d    = '0;
      err_d    = 1'b0;
      issued_d = (IDX_W + 1)'(LAUNCH_N);
      for (int k = 0; k < NUM_WORKERS; k++) begin
        if (LAUNCH_MASK[k]) conf_d[k] = VEC_W'(k);
      end
    end else if (state_q == RUN && grant_valid) begin
      hold_d = grant;
      ptr_d  = (grant_idx == PTR_W'(NUM_WORKERS - 1)) ? '0 : grant_idx + 1'b1;
      if (g_in_range) begin
        we_d   = 1'b1;
        addr_d = g_conf[IDX_W-1:0];
        data_d = transient[grant_idx];
      end else begin
        err_d = 1'b1;
      end
      if (issued_q < TOTAL) begin
        start_d           = grant;
        conf_d[grant_idx] = VEC_W'(issued_q);
        issued_d          = issued_q + 1'b1;
      end else begin
        ack_d    = grant;
        active_d = active_q & ~grant;
      end
    end
  end

  assign busy_d   = (state_d == LAUNCH) || (state_d == RUN);
  assign finish_d = (state_d == FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      hold_q   <= '0;
      ptr_q    <= '0;
      issued_q <= '0;
      err_q    <= 1'b0;
      conf_q   <= '0;
      start_q  <= '0;
      ack_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      active_q <= active_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
      issued_q <= issued_d;
      err_q    <= err_d;
      conf_q   <= conf_d;
      start_q  <= start_d;
      ack_q    <= ack_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      finish_q <= finish_d;
    end
  end

  assign busy         = busy_q;
  assign finish       = finish_q;
  assign err          = err_q;
  assign worker_start = start_q;
  assign worker_conf  = conf_q;
  assign worker_ack   = ack_q;
  assign res_we       = we_q;
  assign res_addr     = addr_q;
  assign res_data     = data_q;
  assign issued       = issued_q;

endmodule

// File: tb/tb_grn_scheduler.sv
// Self-checking bench: a behavioural worker pool plus a rule-level scheduler model.
module tb_grn_scheduler;

  localparam int VW = 69;
  localparam int RW = 32;
  localparam int NA = 4;
  localparam int TA = 8;
  localparam int IA = 3;
  localparam int NB = 16;
  localparam int TB = 4;
  localparam int IB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, go_a, go_b;

  logic a_busy, a_finish, a_err, a_we;
  logic [NA-1:0] a_start, a_ack, a_done;
  logic [NA*VW-1:0] a_conf, a_cout;
  logic [NA*RW-1:0] a_tr;
  logic [IA-1:0] a_addr;
  logic [RW-1:0] a_data;
  logic [IA:0] a_issued;

  logic b_busy, b_finish, b_err, b_we;
  logic [NB-1:0] b_start, b_ack, b_done;
  logic [NB*VW-1:0] b_conf, b_cout;
  logic [NB*RW-1:0] b_tr;
  logic [IB-1:0] b_addr;
  logic [RW-1:0] b_data;
  logic [IB:0] b_issued;

  grn_scheduler #(.NUM_WORKERS(NA), .VEC_W(VW), .TOTAL_STATES(TA), .RES_W(RW), .IDX_W(IA)) dut_a (
    .clk(clk), .rst(rst), .go(go_a), .busy(a_busy), .finish(a_finish), .err(a_err),
    .worker_start(a_start), .worker_conf(a_conf), .worker_ack(a_ack), .worker_done(a_done),
    .worker_conf_out(a_cout), .worker_transient(a_tr),
    .res_we(a_we), .res_addr(a_addr), .res_data(a_data), .issued(a_issued));

  grn_scheduler #(.NUM_WORKERS(NB), .VEC_W(VW), .TOTAL_STATES(TB), .RES_W(RW), .IDX_W(IB)) dut_b (
    .clk(clk), .rst(rst), .go(go_b), .busy(b_busy), .finish(b_finish), .err(b_err),
    .worker_start(b_start), .worker_conf(b_conf), .worker_ack(b_ack), .worker_done(b_done),
    .worker_conf_out(b_cout), .worker_transient(b_tr),
    .res_we(b_we), .res_addr(b_addr), .res_data(b_data), .issued(b_issued));

  int total = 0;
  int bad   = 0;

  bit sel, go, auto_mode, rand_dly, rand_tr;
  int nw, nt, iw;
  int bad_conf = -1;

  // Worker pool model
  bit            w_done[16], w_drop[16], w_go[16], w_run[16];
  int            w_cnt[16];
  logic [VW-1:0] w_conf[16], w_cout[16];
  logic [RW-1:0] w_tr[16];

  // Scheduler model
  int m_phase;  // 0 idle, 1 launch, 2 run, 3 finish
  bit m_active[16], m_hold[16];
  int m_ptr, m_issued;
  bit m_err;

  logic [15:0]   e_start, e_ack;
  logic [VW-1:0] e_conf[16];
  bit            e_we, e_busy, e_finish;
  int            e_addr;
  logic [RW-1:0] e_data;

  logic [15:0]   o_start, o_ack;
  logic [VW-1:0] o_conf[16];
  bit            o_we, o_busy, o_finish, o_err;
  int            o_addr, o_issued, last_idx;
  logic [RW-1:0] o_data;

  int            wr_cnt[16];
  logic [RW-1:0] got_mem[16], exp_mem[16];
  int            n_writes, n_acks;
  logic [15:0]   start_seen;
  int            order[4];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_workers();
    for (int k = 0; k < 16; k++) begin
      w_done[k] = 0; w_drop[k] = 0; w_go[k] = 0; w_run[k] = 0; w_cnt[k] = 0;
      w_conf[k] = '0; w_cout[k] = '0; w_tr[k] = '0;
    end
  endtask

  task automatic clear_sb();
    for (int a = 0; a < 16; a++) begin
      wr_cnt[a] = 0; got_mem[a] = '0; exp_mem[a] = '0;
    end
    n_writes = 0; n_acks = 0; start_seen = '0;
  endtask

  task automatic drive();
    go_a = go && !sel;
    go_b = go && sel;
    for (int k = 0; k < 16; k++) begin
      if (k < NA) begin
        a_done[k] = !sel && w_done[k];
        a_cout[k*VW +: VW] = w_cout[k];
        a_tr[k*RW +: RW] = w_tr[k];
      end
      b_done[k] = sel && w_done[k];
      b_cout[k*VW +: VW] = w_cout[k];
      b_tr[k*RW +: RW] = w_tr[k];
    end
  endtask

  // Computes what the scheduler must show after the coming clock edge.
  task automatic predict();
    int g, k, l;
    e_start = '0; e_ack = '0; e_we = 0;
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_issued = 0; m_err = 0;
      for (int i = 0; i < 16; i++) begin
        m_active[i] = 0; m_hold[i] = 0; e_conf[i] = '0;
      end
      e_addr = 0; e_data = '0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (go) begin
        l = (nw < nt) ? nw : nt;
        for (int i = 0; i < 16; i++) begin
          m_active[i] = (i < l);
          m_hold[i]   = (i < l);
          if (i < l) begin
            e_start[i] = 1'b1;
            e_conf[i]  = VW'(i);
          end
        end
        m_issued = l; m_ptr = 0; m_err = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
      for (int i = 0; i < 16; i++) m_hold[i] = 0;
    end else begin
      l = 0;
      for (int i = 0; i < nw; i++) if (m_active[i]) l++;
      g = -1;
      for (int i = 0; i < nw; i++) begin
        k = (m_ptr + i) % nw;
        if (g < 0 && w_done[k] && m_active[k] && !m_hold[k]) g = k;
      end
      for (int i = 0; i < 16; i++) m_hold[i] = 0;
      if (l == 0) begin
        m_phase = 3;
      end else if (g >= 0) begin
        if ((w_cout[g] >> iw) != '0) begin
          m_err = 1;
        end else begin
          e_we = 1;
          e_addr = int'(w_cout[g] % (69'd1 << iw));
          e_data = w_tr[g];
        end
        if (m_issued < nt) begin
          e_start[g] = 1'b1;
          e_conf[g]  = VW'(m_issued);
          m_issued++;
        end else begin
          e_ack[g] = 1'b1;
          m_active[g] = 0;
        end
        m_ptr = (g + 1) % nw;
        m_hold[g] = 1;
      end
    end
    e_busy   = (m_phase == 1 || m_phase == 2);
    e_finish = (m_phase == 3);
  endtask

  task automatic observe();
    for (int k = 0; k < 16; k++) begin
      if (sel) o_conf[k] = b_conf[k*VW +: VW];
      else if (k < NA) o_conf[k] = a_conf[k*VW +: VW];
      else o_conf[k] = '0;
    end
    o_start  = sel ? b_start : {12'b0, a_start};
    o_ack    = sel ? b_ack : {12'b0, a_ack};
    o_we     = sel ? b_we : a_we;
    o_addr   = sel ? int'(b_addr) : int'(a_addr);
    o_data   = sel ? b_data : a_data;
    o_busy   = sel ? b_busy : a_busy;
    o_finish = sel ? b_finish : a_finish;
    o_err    = sel ? b_err : a_err;
    o_issued = sel ? int'(b_issued) : int'(a_issued);
    last_idx = -1;
    for (int k = 15; k >= 0; k--) if (o_start[k] || o_ack[k]) last_idx = k;
  endtask

  task automatic compare();
    check("start", o_start, e_start);
    check("ack", o_ack, e_ack);
    check("we", o_we, e_we);
    if (e_we) begin
      check("addr", o_addr, e_addr);
      check("data", o_data, e_data);
    end
    check("busy", o_busy, e_busy);
    check("finish", o_finish, e_finish);
    check("err", o_err, m_err);
    check("issued", o_issued, m_issued);
    for (int k = 0; k < nw; k++) if (e_start[k]) check("conf", o_conf[k], e_conf[k]);
    if (o_we && o_addr < 16) begin
      got_mem[o_addr] = o_data;
      wr_cnt[o_addr]++;
      n_writes++;
    end
    n_acks += $countones(o_ack);
    start_seen |= o_start;
  endtask

  task automatic raise(input int k, input logic [VW-1:0] cout, input logic [RW-1:0] tr);
    w_done[k] = 1; w_cout[k] = cout; w_tr[k] = tr;
    if (int'(cout) < 16) exp_mem[int'(cout)] = tr;
  endtask

  task automatic worker_update();
    logic [RW-1:0] tr;
    for (int k = 0; k < nw; k++) begin
      if (o_start[k]) begin
        w_conf[k] = o_conf[k]; w_drop[k] = 1; w_go[k] = 1;
        w_cnt[k] = rand_dly ? int'($urandom_range(1, 8)) : 5 + k;
      end else if (o_ack[k]) begin
        w_drop[k] = 1; w_go[k] = 0;
      end else if (w_drop[k]) begin
        w_done[k] = 0; w_drop[k] = 0; w_run[k] = w_go[k];
      end else if (w_run[k] && auto_mode) begin
        if (w_cnt[k] <= 1) begin
          w_run[k] = 0;
          tr = rand_tr ? RW'($urandom) : RW'(w_conf[k] * 3);
          if (int'(w_conf[k]) == bad_conf) begin
            w_done[k] = 1; w_cout[k] = VW'(32'h20); w_tr[k] = tr;
          end else begin
            raise(k, w_conf[k], tr);
          end
        end else begin
          w_cnt[k]--;
        end
      end
    end
  endtask

  task automatic tick();
    drive();
    predict();
    @(negedge clk);
    observe();
    compare();
    worker_update();
  endtask

  task automatic run_to_finish(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_finish) break;
    end
    check("finish_reached", o_finish, 1'b1);
  endtask

  task automatic start_run(input bit s);
    sel = s;
    nw = s ? NB : NA; nt = s ? TB : TA; iw = s ? IB : IA;
    reset_workers();
    clear_sb();
    go = 1; tick(); go = 0;
  endtask

  initial begin
    rst = 1; go = 0; auto_mode = 1; rand_dly = 0; rand_tr = 0;
    go_a = 0; go_b = 0; a_done = '0; b_done = '0;
    a_cout = '0; b_cout = '0; a_tr = '0; b_tr = '0;
    reset_workers(); clear_sb();
    sel = 1; nw = NB; nt = TB; iw = IB;
    @(negedge clk);
    tick();
    check("rst_b_finish", o_finish, 1'b0);
    sel = 0; nw = NA; nt = TA; iw = IA;
    tick();
    check("rst_a_conf", a_conf, '0);
    rst = 0;
    tick();

    // Full run, fixed worker latency, transient = 3*conf; a go mid-run is ignored
    start_run(0);
    check("launch_start", o_start, 16'h000f);
    for (int i = 0; i < 10; i++) tick();
    go = 1; tick(); go = 0;
    run_to_finish(400);
    check("a_writes", n_writes, TA);
    check("a_acks", n_acks, NA);
    check("a_issued", o_issued, TA);
    check("a_busy_end", o_busy, 1'b0);
    for (int a = 0; a < TA; a++) begin
      check("a_res", got_mem[a], RW'(3 * a));
      check("a_once", wr_cnt[a], 1);
    end

    // Directed arbitration: move the pointer to 2, then all four finish together
    auto_mode = 0;
    start_run(0);
    tick();
    tick();
    raise(0, VW'(0), 32'd100);
    raise(1, VW'(1), 32'd101);
    for (int i = 0; i < 4; i++) tick();
    raise(0, VW'(4), 32'd104);
    raise(1, VW'(5), 32'd105);
    raise(2, VW'(2), 32'd102);
    raise(3, VW'(3), 32'd103);
    for (int i = 0; i < 4; i++) begin
      tick();
      order[i] = last_idx;
    end
    check("order0", order[0], 2);
    check("order1", order[1], 3);
    check("order2", order[2], 0);
    check("order3", order[3], 1);
    tick(); tick();
    w_done[0] = 1; w_cout[0] = VW'(0); w_tr[0] = 32'd999;
    raise(2, VW'(6), 32'd106);
    raise(3, VW'(7), 32'd107);
    run_to_finish(40);
    for (int a = 0; a < TA; a++) begin
      check("d_res", got_mem[a], RW'(100 + a));
      check("d_once", wr_cnt[a], 1);
    end

    // Out-of-range returned configuration, random latency and transients
    auto_mode = 1; rand_dly = 1; rand_tr = 1; bad_conf = 5;
    start_run(0);
    run_to_finish(600);
    check("e_err", o_err, 1'b1);
    check("e_writes", n_writes, TA - 1);
    check("e_nowrite5", wr_cnt[5], 0);
    check("e_acks", n_acks, NA);
    for (int a = 0; a < TA; a++) if (a != 5) check("e_res", got_mem[a], exp_mem[a]);
    bad_conf = -1;

    // Reset in the middle of a run, then relaunch
    start_run(0);
    for (int i = 0; i < 300; i++) begin
      if (n_acks >= 1) break;
      tick();
    end
    check("pre_rst_ack", n_acks >= 1, 1'b1);
    rst = 1; tick();
    check("rst_start", o_start, 16'h0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_issued", o_issued, 0);
    check("rst_conf", a_conf, '0);
    rst = 0;
    start_run(0);
    check("re_start", o_start, 16'h000f);
    check("re_conf0", o_conf[0], VW'(0));
    check("re_conf3", o_conf[3], VW'(3));
    run_to_finish(600);
    check("re_writes", n_writes, TA);
    check("re_err", o_err, 1'b0);

    // Fewer configurations than workers
    start_run(1);
    run_to_finish(400);
    check("b_upper_idle", start_seen[15:4], 12'h0);
    check("b_writes", n_writes, TB);
    check("b_acks", n_acks, TB);
    check("b_issued", o_issued, TB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
